// File: rtl/wrr_stream_arbiter_pkg.sv
// Shared types and helpers for the stream crossbar arbiters.
package wrr_stream_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Wraps back to 0 after count-1, so repeated calls walk a ring of requesters.
    function automatic int next_index(input int idx, input int count);
        return (idx + 1 >= count) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wrr_stream_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible index after start, start itself last.
module rr_pick
    import wrr_stream_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] index
);

    int              cand;
    logic [IW-1:0]   cand_idx;

    always_comb begin
        found    = 1'b0;
        index    = start;
        cand     = int'(start);
        cand_idx = start;
        for (int k = 0; k < N; k++) begin
            cand     = next_index(cand, N);
            cand_idx = IW'(cand);
            if (!found && eligible[cand_idx]) begin
                found = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/wrr_stream_arbiter.sv
// Packet-locked weighted round-robin arbiter sharing one crossbar master output
// between S_DATA_COUNT requesters; grant holds from first beat to accepted last beat.
module wrr_stream_arbiter
    import wrr_stream_arbiter_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2,
    parameter int WEIGHT_WIDTH = 4,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0]                   s_last_i,
    input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
    output logic [S_DATA_COUNT-1:0]                   s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                   m_data_o,
    output logic                                      m_last_o,
    output logic [T_ID___WIDTH-1:0]                   m_id_o,
    output logic                                      m_valid_o,
    input  logic                                      m_ready_i,
    input  logic                                      cfg_we_i,
    input  logic [T_ID___WIDTH-1:0]                   cfg_idx_i,
    input  logic [WEIGHT_WIDTH-1:0]                   cfg_weight_i,
    output logic                                      busy_o
);

    arb_state_t                state;
    logic [T_ID___WIDTH-1:0]   grant;
    logic [T_ID___WIDTH-1:0]   ptr;
    logic [WEIGHT_WIDTH-1:0]   credit;
    logic [WEIGHT_WIDTH-1:0]   weight [S_DATA_COUNT];

    logic [S_DATA_COUNT-1:0]   eligible;
    logic                      keep;
    logic                      pick_found;
    logic [T_ID___WIDTH-1:0]   pick_idx;
    logic                      xfer;

    // A zero weight removes the requester from arbitration entirely.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            eligible[i] = s_valid_i[i] && (weight[i] != '0);
        end
    end

    assign keep = (credit != '0) && eligible[ptr];

    rr_pick #(
        .N  (S_DATA_COUNT),
        .IW (T_ID___WIDTH)
    ) u_pick (
        .eligible (eligible),
        .start    (ptr),
        .found    (pick_found),
        .index    (pick_idx)
    );

    assign xfer = m_valid_o && m_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            ptr    <= T_ID___WIDTH'(S_DATA_COUNT - 1);
            credit <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (keep) begin
                        grant  <= ptr;
                        credit <= credit - 1'b1;
                        state  <= BUSY;
                    end else if (pick_found) begin
                        grant  <= pick_idx;
                        ptr    <= pick_idx;
                        credit <= weight[pick_idx] - 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer && m_last_o) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Weight updates never touch loaded credit; a selection this cycle sees the old weight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < S_DATA_COUNT; i++) begin
                weight[i] <= WEIGHT_WIDTH'(1);
            end
        end else if (cfg_we_i && (int'(cfg_idx_i) < S_DATA_COUNT)) begin
            weight[cfg_idx_i] <= cfg_weight_i;
        end
    end

    always_comb begin
        m_valid_o = 1'b0;
        m_last_o  = 1'b0;
        m_data_o  = '0;
        s_ready_o = '0;
        if (state == BUSY) begin
            m_valid_o        = s_valid_i[grant];
            m_last_o         = s_last_i[grant];
            m_data_o         = s_data_i[grant];
            s_ready_o[grant] = m_ready_i;
        end
    end

    assign m_id_o = grant;
    assign busy_o = (state == BUSY);

endmodule

// File: tb/tb_wrr_stream_arbiter.sv
// Directed self-checking bench for wrr_stream_arbiter (2 requesters, 8-bit data).
module tb_wrr_stream_arbiter;

    logic             clk;
    logic             rst_n;
    logic [1:0][7:0]  s_data_i;
    logic [1:0]       s_last_i;
    logic [1:0]       s_valid_i;
    logic [1:0]       s_ready_o;
    logic [7:0]       m_data_o;
    logic             m_last_o;
    logic [0:0]       m_id_o;
    logic             m_valid_o;
    logic             m_ready_i;
    logic             cfg_we_i;
    logic [0:0]       cfg_idx_i;
    logic [3:0]       cfg_weight_i;
    logic             busy_o;

    int total;
    int bad;

    int         got_id   [16];
    logic [7:0] got_data [16];
    int         got_cyc  [16];
    int         got_n;

    wrr_stream_arbiter #(
        .T_DATA_WIDTH (8),
        .S_DATA_COUNT (2),
        .WEIGHT_WIDTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data_i     (s_data_i),
        .s_last_i     (s_last_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .m_data_o     (m_data_o),
        .m_last_o     (m_last_o),
        .m_id_o       (m_id_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_idx_i    (cfg_idx_i),
        .cfg_weight_i (cfg_weight_i),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Records accepted beats until 'want' are seen or the cycle budget runs out.
    task automatic collect(input int want, input int budget);
        got_n = 0;
        for (int c = 0; c < budget && got_n < want; c++) begin
            @(negedge clk);
            if (m_valid_o && m_ready_i) begin
                got_id[got_n]   = int'(m_id_o);
                got_data[got_n] = m_data_o;
                got_cyc[got_n]  = c;
                got_n++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic write_weight(input logic [0:0] idx, input logic [3:0] w);
        cfg_we_i     = 1'b1;
        cfg_idx_i    = idx;
        cfg_weight_i = w;
        @(posedge clk); #1;
        cfg_we_i     = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        s_valid_i = 2'b11;
        s_last_i  = 2'b11;
        s_data_i[0] = 8'hA0;
        s_data_i[1] = 8'hB1;
        m_ready_i = 1'b1;
        cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_weight_i = '0;
        @(negedge clk);
        total++;
        if ({m_valid_o, m_last_o, m_data_o, m_id_o, s_ready_o, busy_o} !== 14'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got valid=%b last=%b data=%h id=%0d ready=%b busy=%b, want all 0",
                     m_valid_o, m_last_o, m_data_o, m_id_o, s_ready_o, busy_o);
        end
        s_valid_i = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (busy_o !== 1'b0 || m_valid_o !== 1'b0 || m_id_o !== 1'b0 || s_ready_o !== 2'b00) begin
                bad++;
                $display("[TB] FAIL idle_after_reset: got busy=%b valid=%b id=%0d ready=%b, want 0 0 0 00",
                         busy_o, m_valid_o, m_id_o, s_ready_o);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_plain_rr;
        int exp_id;
        s_valid_i = 2'b11;
        s_last_i  = 2'b11;
        collect(4, 20);
        total++;
        if (got_n !== 4) begin
            bad++;
            $display("[TB] FAIL rr_count: got %0d beats, want 4", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            exp_id = i % 2;
            total++;
            if (got_id[i] !== exp_id || got_data[i] !== (exp_id == 0 ? 8'hA0 : 8'hB1)) begin
                bad++;
                $display("[TB] FAIL rr_grant[%0d]: got id=%0d data=%h, want id=%0d", i, got_id[i], got_data[i], exp_id);
            end
            if (i > 0) begin
                total++;
                if (got_cyc[i] - got_cyc[i-1] !== 2) begin
                    bad++;
                    $display("[TB] FAIL rr_spacing[%0d]: got %0d cycles, want 2", i, got_cyc[i] - got_cyc[i-1]);
                end
            end
        end
        s_valid_i = 2'b00;
    endtask

    task automatic test_weighted;
        int exp_seq [6] = '{0, 0, 1, 0, 0, 1};
        write_weight(1'b0, 4'd2);
        write_weight(1'b1, 4'd1);
        s_valid_i = 2'b11;
        s_last_i  = 2'b11;
        collect(6, 30);
        total++;
        if (got_n !== 6) begin
            bad++;
            $display("[TB] FAIL wrr_count: got %0d beats, want 6", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            total++;
            if (got_id[i] !== exp_seq[i]) begin
                bad++;
                $display("[TB] FAIL wrr_grant[%0d]: got id=%0d, want %0d", i, got_id[i], exp_seq[i]);
            end
        end
        s_valid_i = 2'b00;
        write_weight(1'b0, 4'd1);
    endtask

    task automatic test_packet_lock;
        int k;
        logic [7:0] exp_data;
        k = 0;
        s_valid_i = 2'b11;
        s_last_i  = 2'b10;
        s_data_i[0] = 8'h10;
        s_data_i[1] = 8'hB1;
        m_ready_i = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            total++;
            if (busy_o !== ((c >= 1 && c <= 4) || c == 6)) begin
                bad++;
                $display("[TB] FAIL lock_busy[c%0d]: got %b", c, busy_o);
            end
            if (c >= 1 && c <= 4) begin
                exp_data = 8'h10 + 8'(k);
                total++;
                if (m_id_o !== 1'b0 || m_data_o !== exp_data || m_last_o !== (k == 3) || s_ready_o !== 2'b01) begin
                    bad++;
                    $display("[TB] FAIL lock_beat[%0d]: got id=%0d data=%h last=%b ready=%b, want id=0 data=%h last=%b ready=01",
                             k, m_id_o, m_data_o, m_last_o, s_ready_o, exp_data, (k == 3));
                end
            end
            if (c == 6) begin
                total++;
                if (m_id_o !== 1'b1 || m_data_o !== 8'hB1 || s_ready_o !== 2'b10) begin
                    bad++;
                    $display("[TB] FAIL lock_switch: got id=%0d data=%h ready=%b, want id=1 data=b1 ready=10",
                             m_id_o, m_data_o, s_ready_o);
                end
            end
            @(posedge clk); #1;
            if (c >= 1 && c <= 4) begin
                k++;
                s_data_i[0] = 8'h10 + 8'(k);
                s_last_i[0] = (k == 3);
            end
        end
        s_valid_i = 2'b00;
    endtask

    task automatic test_backpressure;
        logic rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int k;
        logic [7:0] exp_data;
        k = 0;
        s_valid_i = 2'b01;
        s_last_i  = 2'b00;
        s_data_i[0] = 8'h40;
        m_ready_i = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c >= 1 && c <= 5) m_ready_i = rdy[c-1];
            @(negedge clk);
            if (c == 0 || c == 6) begin
                total++;
                if (busy_o !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL bp_idle[c%0d]: got busy=%b, want 0", c, busy_o);
                end
            end else begin
                exp_data = 8'h40 + 8'(k);
                total++;
                if (busy_o !== 1'b1 || m_valid_o !== 1'b1 || m_id_o !== 1'b0 || m_data_o !== exp_data ||
                    m_last_o !== (k == 2) || s_ready_o !== {1'b0, rdy[c-1]}) begin
                    bad++;
                    $display("[TB] FAIL bp_beat[c%0d]: got busy=%b valid=%b data=%h last=%b ready=%b, want 1 1 %h %b 0%b",
                             c, busy_o, m_valid_o, m_data_o, m_last_o, s_ready_o, exp_data, (k == 2), rdy[c-1]);
                end
            end
            @(posedge clk); #1;
            if (c >= 1 && c <= 5 && rdy[c-1]) begin
                k++;
                s_data_i[0] = 8'h40 + 8'(k);
                s_last_i[0] = (k == 2);
                if (k == 3) s_valid_i[0] = 1'b0;
            end
        end
        m_ready_i = 1'b1;
        s_valid_i = 2'b00;
    endtask

    task automatic test_weight_zero;
        int k;
        logic [7:0] exp_data;
        k = 0;
        s_valid_i = 2'b10;
        s_last_i  = 2'b00;
        s_data_i[1] = 8'h50;
        m_ready_i = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            if (c == 1) begin
                cfg_we_i = 1'b1; cfg_idx_i = 1'b1; cfg_weight_i = 4'd0;
            end else begin
                cfg_we_i = 1'b0;
            end
            @(negedge clk);
            if (c == 0 || c == 4) begin
                total++;
                if (busy_o !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL w0_idle[c%0d]: got busy=%b, want 0", c, busy_o);
                end
            end else begin
                exp_data = 8'h50 + 8'(k);
                total++;
                if (busy_o !== 1'b1 || m_id_o !== 1'b1 || m_data_o !== exp_data || m_last_o !== (k == 2) ||
                    s_ready_o !== 2'b10) begin
                    bad++;
                    $display("[TB] FAIL w0_beat[%0d]: got busy=%b id=%0d data=%h last=%b ready=%b, want 1 1 %h %b 10",
                             k, busy_o, m_id_o, m_data_o, m_last_o, s_ready_o, exp_data, (k == 2));
                end
            end
            @(posedge clk); #1;
            if (c >= 1 && c <= 3) begin
                k++;
                s_data_i[1] = 8'h50 + 8'(k);
                s_last_i[1] = (k == 2);
                if (k == 3) s_valid_i[1] = 1'b0;
            end
        end
        cfg_we_i = 1'b0;
        s_valid_i = 2'b11;
        s_last_i  = 2'b11;
        s_data_i[0] = 8'hA0;
        s_data_i[1] = 8'hB1;
        collect(3, 12);
        total++;
        if (got_n !== 3) begin
            bad++;
            $display("[TB] FAIL w0_count: got %0d beats, want 3", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            total++;
            if (got_id[i] !== 0) begin
                bad++;
                $display("[TB] FAIL w0_masked[%0d]: got id=%0d, want 0", i, got_id[i]);
            end
        end
        s_valid_i = 2'b10;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (busy_o !== 1'b0 || s_ready_o !== 2'b00) begin
                bad++;
                $display("[TB] FAIL w0_alone[c%0d]: got busy=%b ready=%b, want 0 00", c, busy_o, s_ready_o);
            end
        end
        @(posedge clk); #1;
        s_valid_i = 2'b00;
    endtask

    task automatic test_reset_mid_packet;
        s_valid_i = 2'b01;
        s_last_i  = 2'b00;
        s_data_i[0] = 8'h60;
        m_ready_i = 1'b1;
        for (int c = 0; c <= 1; c++) begin
            @(negedge clk);
            @(posedge clk); #1;
            if (c == 1) s_data_i[0] = 8'h61;
        end
        @(negedge clk);
        total++;
        if (busy_o !== 1'b1 || m_valid_o !== 1'b1 || m_data_o !== 8'h61) begin
            bad++;
            $display("[TB] FAIL rst_pre: got busy=%b valid=%b data=%h, want 1 1 61", busy_o, m_valid_o, m_data_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (m_valid_o !== 1'b0 || s_ready_o !== 2'b00 || busy_o !== 1'b0 || m_id_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_async: got valid=%b ready=%b busy=%b id=%0d, want 0 00 0 0",
                     m_valid_o, s_ready_o, busy_o, m_id_o);
        end
        s_valid_i = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        s_valid_i = 2'b11;
        s_last_i  = 2'b11;
        s_data_i[0] = 8'hA0;
        s_data_i[1] = 8'hB1;
        collect(2, 10);
        total++;
        if (got_n !== 2) begin
            bad++;
            $display("[TB] FAIL rst_count: got %0d beats, want 2", got_n);
        end else begin
            total++;
            if (got_id[0] !== 0 || got_id[1] !== 1) begin
                bad++;
                $display("[TB] FAIL rst_regrant: got ids %0d,%0d, want 0,1", got_id[0], got_id[1]);
            end
        end
        s_valid_i = 2'b00;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_plain_rr();
        test_weighted();
        test_packet_lock();
        test_backpressure();
        test_weight_zero();
        write_weight(1'b1, 4'd0);
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
